pcileech_wifi_link_sequencer: RTL and testbench

Owns the fake Wi-Fi connection state that the BAR register bank exposes. It accepts host commands (scan, connect to index, disconnect) decoded by the BAR write path. It sequences timed scan/auth/assoc phases, with auth retry and backoff, and drives status, current index, RSSI drift and event pulses. The BAR read path samples these outputs directly; it holds no connection state of its own.

---
 rtl/pcileech_wifi_pkg.sv | 44 ++++
 rtl/pcileech_wifi_link_sequencer_if.sv | 45 ++++
 rtl/pcileech_wifi_dwell_timer.sv | 39 +++
 rtl/pcileech_wifi_link_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_pcileech_wifi_link_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pcileech_wifi_pkg.sv
// -----------------------------------------------------------------------------
// pcileech_wifi_pkg
// Shared types and constants for the fake Wi-Fi link sequencer and the BAR
// register bank that exposes it.
//   link_state_e : connection state encoding as seen in LINK_STATUS
//   cmd_op_e     : host command codes decoded from the CMD register
//   evt_t        : bundle of the one-cycle event pulses
//   BAR_*        : byte offsets of the BAR registers
// -----------------------------------------------------------------------------
package pcileech_wifi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_AUTH    = 3'd2,
    ST_ASSOC   = 3'd3,
    ST_CONN    = 3'd4,
    ST_BACKOFF = 3'd5
  } link_state_e;

  typedef enum logic [1:0] {
    OP_NOP        = 2'd0,
    OP_SCAN       = 2'd1,
    OP_CONNECT    = 2'd2,
    OP_DISCONNECT = 2'd3
  } cmd_op_e;

  typedef struct packed {
    logic scan_done;
    logic evt_connected;
    logic evt_lost;
    logic evt_fail;
    logic err_badidx;
  } evt_t;

  localparam logic [7:0] BAR_LINK_STATUS = 8'h00;
  localparam logic [7:0] BAR_SELECT      = 8'h04;
  localparam logic [7:0] BAR_SSID        = 8'h08;
  localparam logic [7:0] BAR_RSSI        = 8'h0C;
  localparam logic [7:0] BAR_SCAN_COUNT  = 8'h10;
  localparam logic [7:0] BAR_SCAN_ENTRY  = 8'h14;
  localparam logic [7:0] BAR_CMD         = 8'h18;

endpackage

// File: rtl/pcileech_wifi_link_sequencer_if.sv
// -----------------------------------------------------------------------------
// pcileech_wifi_link_sequencer_if
// Bundle between the BAR write/read paths (master) and the link sequencer
// (slave).
//   master drives : cmd_valid, cmd_op, cmd_idx, rssi_tbl, auth_fail
//   slave drives  : cmd_ready, link_state, link_up, cur_idx, cur_rssi,
//                   retry_cnt, scan_done, evt_connected, evt_lost, evt_fail,
//                   err_badidx
// rssi_tbl entry i is bits [8i+7:8i].
// -----------------------------------------------------------------------------
interface pcileech_wifi_link_sequencer_if #(
  parameter int unsigned NUM_NETS = 4
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [7:0]            cmd_idx;
  logic [8*NUM_NETS-1:0] rssi_tbl;
  logic                  auth_fail;

  logic [2:0]            link_state;
  logic                  link_up;
  logic [7:0]            cur_idx;
  logic [7:0]            cur_rssi;
  logic [1:0]            retry_cnt;
  logic                  scan_done;
  logic                  evt_connected;
  logic                  evt_lost;
  logic                  evt_fail;
  logic                  err_badidx;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, rssi_tbl, auth_fail,
    input  cmd_ready, link_state, link_up, cur_idx, cur_rssi, retry_cnt,
           scan_done, evt_connected, evt_lost, evt_fail, err_badidx
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, rssi_tbl, auth_fail,
    output cmd_ready, link_state, link_up, cur_idx, cur_rssi, retry_cnt,
           scan_done, evt_connected, evt_lost, evt_fail, err_badidx
  );

endinterface

// File: rtl/pcileech_wifi_dwell_timer.sv
// -----------------------------------------------------------------------------
// pcileech_wifi_dwell_timer
// 32-bit up counter that wraps to zero after reaching i_limit-1.
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : restart at zero on the next cycle (state entry)
//   i_periodic : qualifies o_wrap (free-running period mode)
//   i_limit    : period / dwell length in cycles
//   o_expire   : high on the last cycle of the period (count == limit-1)
//   o_wrap     : o_expire while in periodic mode
// A state with dwell T therefore sees o_expire on its T-th cycle.
// -----------------------------------------------------------------------------
module pcileech_wifi_dwell_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_periodic,
  input  logic [31:0] i_limit,
  output logic        o_expire,
  output logic        o_wrap
);

  logic [31:0] r_count;
  logic        w_terminal;

  assign w_terminal = (r_count == (i_limit - 32'd1));
  assign o_expire   = w_terminal;
  assign o_wrap     = w_terminal && i_periodic;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= 32'd0;
    end else if (w_terminal) begin
      r_count <= 32'd0;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule

// File: rtl/pcileech_wifi_link_sequencer.sv
// -----------------------------------------------------------------------------
// pcileech_wifi_link_sequencer
// Owns the fake Wi-Fi connection state shown through the BAR bank. Accepts
// SCAN / CONNECT / DISCONNECT commands and walks SCAN -> AUTH -> ASSOC -> CONN
// with timed dwells, auth retry via BACKOFF, and RSSI drift while connected.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pcileech_wifi_link_sequencer_if (command
//              handshake, RSSI table, fault inject, status and event pulses)
// All status outputs and pulses are registered; cmd_ready is decoded from
// the state register.
// -----------------------------------------------------------------------------
module pcileech_wifi_link_sequencer
  import pcileech_wifi_pkg::*;
#(
  parameter int unsigned NUM_NETS    = 4,
  parameter int unsigned T_SCAN      = 1000,
  parameter int unsigned T_AUTH      = 500,
  parameter int unsigned T_ASSOC     = 500,
  parameter int unsigned T_BACKOFF   = 200,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned RSSI_FLOOR  = 45,
  parameter int unsigned RSSI_PERIOD = 256
) (
  input logic                           clk,
  input logic                           rst,
  pcileech_wifi_link_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_NETS > 1) ? $clog2(NUM_NETS) : 1;

  link_state_e r_state, w_state_next;
  logic        r_pending, w_pending_next;
  logic [1:0]  r_retry_cnt, w_retry_cnt_next;
  logic [7:0]  r_cur_idx, w_cur_idx_next;
  logic [7:0]  r_cur_rssi, w_cur_rssi_next;
  evt_t        r_evt, w_evt_next;

  logic [31:0] w_limit;
  logic        w_expire;
  logic        w_wrap;
  logic        w_clear;
  logic        w_ready;
  logic        w_accept;
  logic        w_idx_ok;
  logic        w_bad_connect;
  cmd_op_e     w_op;
  logic [7:0]  w_base_rssi;
  logic [7:0]  w_rssi_arr [NUM_NETS];

  // Unpack the flat table so the base RSSI is a plain array lookup.
  generate
    for (genvar gi = 0; gi < NUM_NETS; gi++) begin : g_rssi
      assign w_rssi_arr[gi] = bus.rssi_tbl[8*gi +: 8];
    end
  endgenerate

  // cur_idx only ever latches an in-range index, so the low bits suffice.
  assign w_base_rssi   = w_rssi_arr[r_cur_idx[IDX_W-1:0]];

  assign w_op          = cmd_op_e'(bus.cmd_op);
  assign w_ready       = (r_state == ST_IDLE) || (r_state == ST_CONN) ||
                         (r_state == ST_BACKOFF);
  assign w_accept      = bus.cmd_valid && w_ready;
  assign w_idx_ok      = (bus.cmd_idx < 8'(NUM_NETS));
  assign w_bad_connect = w_accept && (w_op == OP_CONNECT) && !w_idx_ok;

  // Timer restarts on every state change; in CONN it free-runs as the
  // RSSI drift period.
  assign w_clear = (w_state_next != r_state);

  always_comb begin
    w_limit = 32'(RSSI_PERIOD);
    case (r_state)
      ST_SCAN:    w_limit = 32'(T_SCAN);
      ST_AUTH:    w_limit = 32'(T_AUTH);
      ST_ASSOC:   w_limit = 32'(T_ASSOC);
      ST_BACKOFF: w_limit = 32'(T_BACKOFF);
      default:    w_limit = 32'(RSSI_PERIOD);
    endcase
  end

  pcileech_wifi_dwell_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_periodic (r_state == ST_CONN),
    .i_limit    (w_limit),
    .o_expire   (w_expire),
    .o_wrap     (w_wrap)
  );

  always_comb begin
    w_state_next     = r_state;
    w_pending_next   = r_pending;
    w_retry_cnt_next = r_retry_cnt;
    w_cur_idx_next   = r_cur_idx;
    w_cur_rssi_next  = r_cur_rssi;
    w_evt_next       = '0;

    // An out-of-range CONNECT only raises the error pulse, whatever the state.
    w_evt_next.err_badidx = w_bad_connect;

    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_op == OP_SCAN)) begin
          w_state_next   = ST_SCAN;
          w_pending_next = 1'b0;
        end else if (w_accept && (w_op == OP_CONNECT) && w_idx_ok) begin
          w_state_next     = ST_SCAN;
          w_pending_next   = 1'b1;
          w_retry_cnt_next = 2'd0;
          w_cur_idx_next   = bus.cmd_idx;
        end
      end

      ST_SCAN: begin
        if (w_expire) begin
          if (r_pending) begin
            w_state_next = ST_AUTH;
          end else begin
            w_state_next         = ST_IDLE;
            w_evt_next.scan_done = 1'b1;
          end
        end
      end

      ST_AUTH: begin
        if (w_expire) begin
          if (!bus.auth_fail) begin
            w_state_next = ST_ASSOC;
          end else if (r_retry_cnt < 2'(MAX_RETRY)) begin
            w_state_next     = ST_BACKOFF;
            w_retry_cnt_next = r_retry_cnt + 2'd1;
          end else begin
            w_state_next        = ST_IDLE;
            w_pending_next      = 1'b0;
            w_evt_next.evt_fail = 1'b1;
          end
        end
      end

      ST_ASSOC: begin
        if (w_expire) begin
          w_state_next             = ST_CONN;
          w_cur_rssi_next          = w_base_rssi;
          w_evt_next.evt_connected = 1'b1;
        end
      end

      ST_CONN: begin
        // Any accepted command takes the cycle; drift only when idle.
        if (w_accept) begin
          if (w_op == OP_DISCONNECT) begin
            w_state_next        = ST_IDLE;
            w_pending_next      = 1'b0;
            w_cur_rssi_next     = 8'd0;
            w_evt_next.evt_lost = 1'b1;
          end else if ((w_op == OP_CONNECT) && w_idx_ok) begin
            // Roam: straight to AUTH on the new network, no scan.
            w_state_next        = ST_AUTH;
            w_pending_next      = 1'b1;
            w_retry_cnt_next    = 2'd0;
            w_cur_idx_next      = bus.cmd_idx;
            w_cur_rssi_next     = 8'd0;
            w_evt_next.evt_lost = 1'b1;
          end
        end else if (w_wrap) begin
          if (r_cur_rssi > 8'(RSSI_FLOOR)) begin
            w_cur_rssi_next = r_cur_rssi - 8'd1;
          end else begin
            w_cur_rssi_next = w_base_rssi;
          end
        end
      end

      ST_BACKOFF: begin
        // DISCONNECT beats a same-cycle expiry.
        if (w_accept && (w_op == OP_DISCONNECT)) begin
          w_state_next   = ST_IDLE;
          w_pending_next = 1'b0;
        end else if (w_expire) begin
          w_state_next = ST_AUTH;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pending   <= 1'b0;
      r_retry_cnt <= 2'd0;
      r_cur_idx   <= 8'd0;
      r_cur_rssi  <= 8'd0;
      r_evt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pending   <= w_pending_next;
      r_retry_cnt <= w_retry_cnt_next;
      r_cur_idx   <= w_cur_idx_next;
      r_cur_rssi  <= w_cur_rssi_next;
      r_evt       <= w_evt_next;
    end
  end

  assign bus.cmd_ready     = w_ready;
  assign bus.link_state    = r_state;
  assign bus.link_up       = (r_state == ST_CONN);
  assign bus.cur_idx       = r_cur_idx;
  assign bus.cur_rssi      = r_cur_rssi;
  assign bus.retry_cnt     = r_retry_cnt;
  assign bus.scan_done     = r_evt.scan_done;
  assign bus.evt_connected = r_evt.evt_connected;
  assign bus.evt_lost      = r_evt.evt_lost;
  assign bus.evt_fail      = r_evt.evt_fail;
  assign bus.err_badidx    = r_evt.err_badidx;

endmodule

// File: tb/tb_pcileech_wifi_link_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pcileech_wifi_link_sequencer
// Directed, table-driven bench. Each table row optionally issues one command
// on its first clock edge, advances a fixed number of edges, then compares
// every status output and the event pulse vector
// {scan_done, evt_connected, evt_lost, evt_fail, err_badidx}.
// Hand-written sequences cover the SCAN ready window and reset in ASSOC.
// -----------------------------------------------------------------------------
module tb_pcileech_wifi_link_sequencer;

  typedef struct {
    bit         cmd;
    logic [1:0] op;
    logic [7:0] idx;
    bit         afail;
    int         n;
    logic [2:0] st;
    logic       up;
    logic [7:0] cidx;
    logic [7:0] rssi;
    logic [1:0] retry;
    logic       rdy;
    logic [4:0] pulse;
  } vec_t;

  localparam logic [1:0] NOP = 2'd0, SCN = 2'd1, CON = 2'd2, DIS = 2'd3;
  localparam logic [2:0] S_IDLE = 3'd0, S_SCAN = 3'd1, S_AUTH = 3'd2,
                         S_ASSOC = 3'd3, S_CONN = 3'd4, S_BACK = 3'd5;
  localparam logic [4:0] P_NONE = 5'b00000, P_SCAN = 5'b10000,
                         P_CONN = 5'b01000, P_LOST = 5'b00100,
                         P_FAIL = 5'b00010, P_BAD  = 5'b00001;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   row_id;
  vec_t tbl[$];

  pcileech_wifi_link_sequencer_if #(.NUM_NETS(4)) bus ();

  pcileech_wifi_link_sequencer #(.NUM_NETS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(bit cmd, logic [1:0] op, logic [7:0] idx,
                             bit afail, int n, logic [2:0] st, logic up,
                             logic [7:0] cidx, logic [7:0] rssi,
                             logic [1:0] retry, logic rdy, logic [4:0] pulse);
    vec_t t;
    t.cmd = cmd; t.op = op; t.idx = idx; t.afail = afail; t.n = n;
    t.st = st; t.up = up; t.cidx = cidx; t.rssi = rssi; t.retry = retry;
    t.rdy = rdy; t.pulse = pulse;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", name, row_id, act, exp);
    end
  endtask

  function automatic logic [4:0] pulses();
    return {bus.scan_done, bus.evt_connected, bus.evt_lost, bus.evt_fail,
            bus.err_badidx};
  endfunction

  task automatic check_all(input logic [2:0] st, input logic up,
                           input logic [7:0] cidx, input logic [7:0] rssi,
                           input logic [1:0] retry, input logic rdy,
                           input logic [4:0] pulse);
    check("link_state", 32'(bus.link_state), 32'(st));
    check("link_up",    32'(bus.link_up),    32'(up));
    check("cur_idx",    32'(bus.cur_idx),    32'(cidx));
    check("cur_rssi",   32'(bus.cur_rssi),   32'(rssi));
    check("retry_cnt",  32'(bus.retry_cnt),  32'(retry));
    check("cmd_ready",  32'(bus.cmd_ready),  32'(rdy));
    check("pulses",     32'(pulses()),       32'(pulse));
  endtask

  task automatic run_vec(input vec_t t);
    bus.auth_fail = t.afail;
    if (t.cmd) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = t.op;
      bus.cmd_idx   = t.idx;
    end
    for (int k = 0; k < t.n; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = NOP;
      bus.cmd_idx   = 8'd0;
    end
    check_all(t.st, t.up, t.cidx, t.rssi, t.retry, t.rdy, t.pulse);
    $display("step %0d: cmd=%0b op=%0d idx=%0d n=%0d -> state=%0d idx=%0d rssi=%0d retry=%0d pulses=%05b",
             row_id, t.cmd, t.op, t.idx, t.n, bus.link_state, bus.cur_idx,
             bus.cur_rssi, bus.retry_cnt, pulses());
  endtask

  initial begin
    int ready_hi;
    int early_done;
    int up_hi;

    checks   = 0;
    failures = 0;
    row_id   = 0;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
    bus.cmd_idx   = 8'd0;
    bus.auth_fail = 1'b0;
    // idx3=60, idx2=80, idx1=75, idx0=47
    bus.rssi_tbl  = {8'd60, 8'd80, 8'd75, 8'd47};

    //          cmd op  idx af  n    state   up cidx rssi rt rdy pulse
    // NOP / DISCONNECT in IDLE do nothing
    tbl.push_back(v(1, NOP, 0, 0, 1,    S_IDLE,  0, 0, 0,  0, 1, P_NONE));
    tbl.push_back(v(1, DIS, 0, 0, 1,    S_IDLE,  0, 0, 0,  0, 1, P_NONE));
    // CONNECT idx1: SCAN 1000, AUTH 500, ASSOC 500, connected on edge 2001
    tbl.push_back(v(1, CON, 1, 0, 1000, S_SCAN,  0, 1, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_AUTH,  0, 1, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 499,  S_AUTH,  0, 1, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_ASSOC, 0, 1, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 499,  S_ASSOC, 0, 1, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_CONN,  1, 1, 75, 0, 1, P_CONN));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_CONN,  1, 1, 75, 0, 1, P_NONE));
    // bad index in CONN, then roam to idx0
    tbl.push_back(v(1, CON, 7, 0, 1,    S_CONN,  1, 1, 75, 0, 1, P_BAD));
    tbl.push_back(v(1, CON, 0, 0, 1,    S_AUTH,  0, 0, 0,  0, 0, P_LOST));
    tbl.push_back(v(0, NOP, 0, 0, 499,  S_AUTH,  0, 0, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_ASSOC, 0, 0, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 499,  S_ASSOC, 0, 0, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_CONN,  1, 0, 47, 0, 1, P_CONN));
    // drift 47 -> 46 -> 45 -> reload 47 every 256 cycles
    tbl.push_back(v(0, NOP, 0, 0, 255,  S_CONN,  1, 0, 47, 0, 1, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_CONN,  1, 0, 46, 0, 1, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 255,  S_CONN,  1, 0, 46, 0, 1, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_CONN,  1, 0, 45, 0, 1, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 255,  S_CONN,  1, 0, 45, 0, 1, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_CONN,  1, 0, 47, 0, 1, P_NONE));
    tbl.push_back(v(1, DIS, 0, 0, 1,    S_IDLE,  0, 0, 0,  0, 1, P_LOST));
    // idx2 with two auth failures then success
    tbl.push_back(v(1, CON, 2, 1, 1500, S_AUTH,  0, 2, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 1, 1,    S_BACK,  0, 2, 0,  1, 1, P_NONE));
    tbl.push_back(v(0, NOP, 0, 1, 199,  S_BACK,  0, 2, 0,  1, 1, P_NONE));
    tbl.push_back(v(0, NOP, 0, 1, 1,    S_AUTH,  0, 2, 0,  1, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 1, 499,  S_AUTH,  0, 2, 0,  1, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 1, 1,    S_BACK,  0, 2, 0,  2, 1, P_NONE));
    tbl.push_back(v(0, NOP, 0, 1, 200,  S_AUTH,  0, 2, 0,  2, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 500,  S_ASSOC, 0, 2, 0,  2, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 500,  S_CONN,  1, 2, 80, 2, 1, P_CONN));
    tbl.push_back(v(1, DIS, 0, 0, 1,    S_IDLE,  0, 2, 0,  2, 1, P_LOST));
    // idx3 with auth_fail held: third failure gives evt_fail
    tbl.push_back(v(1, CON, 3, 1, 2900, S_AUTH,  0, 3, 0,  2, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 1, 1,    S_IDLE,  0, 3, 0,  2, 1, P_FAIL));
    tbl.push_back(v(0, NOP, 0, 0, 1,    S_IDLE,  0, 3, 0,  2, 1, P_NONE));
    // idx == NUM_NETS in IDLE is out of range
    tbl.push_back(v(1, CON, 4, 0, 1,    S_IDLE,  0, 3, 0,  2, 1, P_BAD));
    // DISCONNECT during BACKOFF: IDLE, no evt_lost, no later AUTH
    tbl.push_back(v(1, CON, 1, 1, 1500, S_AUTH,  0, 1, 0,  0, 0, P_NONE));
    tbl.push_back(v(0, NOP, 0, 1, 1,    S_BACK,  0, 1, 0,  1, 1, P_NONE));
    tbl.push_back(v(1, DIS, 0, 1, 1,    S_IDLE,  0, 1, 0,  1, 1, P_NONE));
    tbl.push_back(v(0, NOP, 0, 0, 300,  S_IDLE,  0, 1, 0,  1, 1, P_NONE));

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_all(S_IDLE, 0, 8'd0, 8'd0, 2'd0, 1, P_NONE);
    $display("reset: state=%0d ready=%0b", bus.link_state, bus.cmd_ready);
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      row_id = r + 1;
      run_vec(tbl[r]);
    end

    // SCAN in IDLE: not ready for exactly 1000 cycles, one scan_done
    row_id        = 100;
    bus.auth_fail = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = SCN;
    ready_hi      = 0;
    early_done    = 0;
    up_hi         = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = NOP;
      if (bus.cmd_ready) ready_hi++;
      if (bus.scan_done) early_done++;
      if (bus.link_up) up_hi++;
    end
    check("scan_ready_high_cycles", 32'(ready_hi), 32'd0);
    check("scan_early_done", 32'(early_done), 32'd0);
    check("scan_state_at_1000", 32'(bus.link_state), 32'(S_SCAN));
    tick();
    check_all(S_IDLE, 0, 8'd1, 8'd0, 2'd1, 1, P_SCAN);
    tick();
    check("scan_done_one_shot", 32'(bus.scan_done), 32'd0);
    check("scan_link_up_cycles", 32'(up_hi), 32'd0);
    $display("scan: ready_high=%0d early_done=%0d state=%0d", ready_hi,
             early_done, bus.link_state);

    // Reset asserted during ASSOC
    row_id        = 200;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = CON;
    bus.cmd_idx   = 8'd2;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
    bus.cmd_idx   = 8'd0;
    repeat (1500) tick();
    check("pre_reset_state", 32'(bus.link_state), 32'(S_ASSOC));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all(S_IDLE, 0, 8'd0, 8'd0, 2'd0, 1, P_NONE);
    repeat (600) tick();
    check("post_reset_idle", 32'(bus.link_state), 32'(S_IDLE));
    $display("reset in ASSOC: state=%0d idx=%0d", bus.link_state, bus.cur_idx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
